// File: rtl/hybrid_sequencer_pkg.sv
// Shared types and helpers for the hybrid filter sequencer.
// The drop counter width is used only when HYBRID_SEQ_DROPCNT_EN is defined.
package hybrid_seq_p;

    typedef enum logic [1:0] {IDLE, FILL, COMPUTE, RUN} seq_state_t;

    localparam int DROP_CNT_W = 16;

    // Counter width for a modulo-x counter; never narrower than one bit.
    function automatic int cnt_width(input int x);
        return ($clog2(x) < 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/hybrid_sequencer_if.sv
// Ready/valid result stream from the sequencer's output FIFO to the consumer.
interface hybrid_sequencer_if #(
    parameter int OUT_WIDTH = 12
);
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/hybrid_sequencer_out_fifo.sv
// Small result FIFO with a registered head read; a push into a full FIFO
// is dropped unless a pop frees a slot in the same cycle.
module seq_out_fifo #(
    parameter int OUT_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push,
    input  logic [OUT_WIDTH-1:0] din,
    input  logic                 pop,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 empty,
    output logic                 full,
    output logic                 drop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OUT_WIDTH-1:0] dout_q, dout_d;
    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                 do_pop, do_push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign dout  = dout_q;

    // The head register looks ahead to the next read pointer; a push into an
    // empty FIFO bypasses the memory so the data is ready with out_valid.
    always_comb begin
        do_pop   = pop && !empty && !flush;
        do_push  = push && !flush && (!full || do_pop);
        drop     = push && !flush && full && !do_pop;
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
        if (flush) begin
            dout_d = '0;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din;
        end else begin
            dout_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/hybrid_sequencer.sv
// Single-clock sequencer for the two-stage hybrid filter: clock enables, warm-up FSM
// and result FIFO. Define HYBRID_SEQ_DROPCNT_EN to add the saturating drop_cnt output.
module hybrid_sequencer
    import hybrid_seq_p::*;
#(
    parameter int DSR1       = 2,
    parameter int DSR2       = 6,
    parameter int FILL_TICKS = 6,
    parameter int PIPE_TICKS = 1,
    parameter int OUT_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int P1W       = cnt_width(DSR1),
    localparam int P2W       = cnt_width(DSR2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  restart,
    input  logic [OUT_WIDTH-1:0]  res_in,
    output logic                  en_recurse,
    output logic                  en_ds,
    output logic                  load_back,
    output logic [P1W-1:0]        phase1,
    output logic [P2W-1:0]        phase2,
    output logic                  valid_compute,
    output logic                  overflow,
`ifdef HYBRID_SEQ_DROPCNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    hybrid_sequencer_if.master    out_if
);
    localparam int TICK_MAX = (FILL_TICKS > PIPE_TICKS) ? FILL_TICKS : PIPE_TICKS;
    localparam int TICK_W   = cnt_width(TICK_MAX);

    seq_state_t       state_q, state_d;
    logic [P1W-1:0]   phase1_q, phase1_d;
    logic [P2W-1:0]   phase2_q, phase2_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic             en_recurse_q, en_recurse_d;
    logic             en_ds_q, en_ds_d;
    logic             load_back_q, load_back_d;
    logic             push_arm_q, push_arm_d;
    logic             valid_compute_q, valid_compute_d;
    logic             overflow_q, overflow_d;

    logic active, seq_stop, seq_restart, seq_run, rec_hit, wrap2;
    logic fifo_flush, fifo_pop, fifo_empty, fifo_full, fifo_drop;
    logic [OUT_WIDTH-1:0] fifo_dout;

    assign active      = (state_q != IDLE);
    assign seq_stop    = active && !start;
    assign seq_restart = active && start && restart;
    assign seq_run     = active && start && !restart;
    assign rec_hit     = (phase1_q == P1W'(DSR1 - 1));
    assign wrap2       = (phase2_q == P2W'(DSR2 - 1));
    assign fifo_flush  = seq_stop || seq_restart;
    assign fifo_pop    = out_if.out_ready && !fifo_empty;

    // Strobes are registered from this cycle's counters; the FSM steps on the
    // same downsample tick so valid_compute changes together with en_ds.
    // push_arm remembers whether the tick was issued while already in RUN.
    always_comb begin
        state_d      = state_q;
        phase1_d     = phase1_q;
        phase2_d     = phase2_q;
        tick_d       = tick_q;
        overflow_d   = overflow_q | fifo_drop;
        en_recurse_d = seq_run && rec_hit;
        en_ds_d      = seq_run && rec_hit && wrap2;
        load_back_d  = seq_run && rec_hit && (phase2_q == '0);
        push_arm_d   = en_ds_d && (state_q == RUN);

        if (seq_stop) begin
            state_d  = IDLE;
            phase1_d = '0;
            phase2_d = '0;
            tick_d   = '0;
        end else if (seq_restart) begin
            state_d    = FILL;
            phase1_d   = '0;
            phase2_d   = '0;
            tick_d     = '0;
            overflow_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                state_d = FILL;
            end
        end else begin
            if (rec_hit) begin
                phase1_d = '0;
                phase2_d = wrap2 ? '0 : phase2_q + P2W'(1);
            end else begin
                phase1_d = phase1_q + P1W'(1);
            end
            if (en_ds_d) begin
                case (state_q)
                    FILL: begin
                        if (tick_q == TICK_W'(FILL_TICKS - 1)) begin
                            state_d = COMPUTE;
                            tick_d  = '0;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                    COMPUTE: begin
                        if (tick_q == TICK_W'(PIPE_TICKS - 1)) begin
                            state_d = RUN;
                            tick_d  = '0;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        valid_compute_d = (state_d == COMPUTE) || (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            phase1_q        <= '0;
            phase2_q        <= '0;
            tick_q          <= '0;
            en_recurse_q    <= 1'b0;
            en_ds_q         <= 1'b0;
            load_back_q     <= 1'b0;
            push_arm_q      <= 1'b0;
            valid_compute_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase1_q        <= phase1_d;
            phase2_q        <= phase2_d;
            tick_q          <= tick_d;
            en_recurse_q    <= en_recurse_d;
            en_ds_q         <= en_ds_d;
            load_back_q     <= load_back_d;
            push_arm_q      <= push_arm_d;
            valid_compute_q <= valid_compute_d;
            overflow_q      <= overflow_d;
        end
    end

    seq_out_fifo #(
        .OUT_WIDTH  (OUT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (push_arm_q),
        .din   (res_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

`ifdef HYBRID_SEQ_DROPCNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (seq_restart) begin
            drop_cnt_d = '0;
        end else if (fifo_drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign en_recurse       = en_recurse_q;
    assign en_ds            = en_ds_q;
    assign load_back        = load_back_q;
    assign phase1           = phase1_q;
    assign phase2           = phase2_q;
    assign valid_compute    = valid_compute_q;
    assign overflow         = overflow_q;
    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_dout;

    // fifo_full is only needed inside the FIFO's drop decision.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_hybrid_sequencer.sv
// Directed bench for hybrid_sequencer: strobe timing, warm-up, FIFO, restart,
// reset and a DSR1=DSR2=1 instance. Checks drop_cnt when HYBRID_SEQ_DROPCNT_EN is set.
module tb_hybrid_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, restart, start_b;
    logic [11:0] res_in;

    logic       en_recurse, en_ds, load_back, valid_compute, overflow;
    logic [0:0] phase1;
    logic [2:0] phase2;
    logic       en_recurse_b, en_ds_b, load_back_b, valid_compute_b, overflow_b;
    logic [0:0] phase1_b, phase2_b;
`ifdef HYBRID_SEQ_DROPCNT_EN
    logic [15:0] drop_cnt, drop_cnt_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    hybrid_sequencer_if #(.OUT_WIDTH(12)) out_if ();
    hybrid_sequencer_if #(.OUT_WIDTH(12)) out_if_b ();

    always #5 clk = ~clk;

    hybrid_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .restart       (restart),
        .res_in        (res_in),
        .en_recurse    (en_recurse),
        .en_ds         (en_ds),
        .load_back     (load_back),
        .phase1        (phase1),
        .phase2        (phase2),
        .valid_compute (valid_compute),
        .overflow      (overflow),
`ifdef HYBRID_SEQ_DROPCNT_EN
        .drop_cnt      (drop_cnt),
`endif
        .out_if        (out_if)
    );

    hybrid_sequencer #(.DSR1(1), .DSR2(1)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .start         (start_b),
        .restart       (1'b0),
        .res_in        (res_in),
        .en_recurse    (en_recurse_b),
        .en_ds         (en_ds_b),
        .load_back     (load_back_b),
        .phase1        (phase1_b),
        .phase2        (phase2_b),
        .valid_compute (valid_compute_b),
        .overflow      (overflow_b),
`ifdef HYBRID_SEQ_DROPCNT_EN
        .drop_cnt      (drop_cnt_b),
`endif
        .out_if        (out_if_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic rdy, input logic [11:0] din);
        start            = s;
        restart          = r;
        out_if.out_ready = rdy;
        res_in           = din;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start_b = 1'b0;
        out_if_b.out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        repeat (3) @(posedge clk);
        #1;

        checkOutput("rst_en_recurse", en_recurse, 0);
        checkOutput("rst_en_ds", en_ds, 0);
        checkOutput("rst_load_back", load_back, 0);
        checkOutput("rst_phase1", phase1, 0);
        checkOutput("rst_phase2", phase2, 0);
        checkOutput("rst_valid_compute", valid_compute, 0);
        checkOutput("rst_out_valid", out_if.out_valid, 0);
        checkOutput("rst_out_data", out_if.out_data, 0);
        checkOutput("rst_overflow", overflow, 0);

        rst = 1'b1;
        next_cycle();
        checkOutput("idle_en_recurse", en_recurse, 0);

        // Leave IDLE: this edge is cycle 0 of the schedule.
        applyStimulus(1'b1, 1'b0, 1'b1, 12'h100);
        next_cycle();
        cyc = 0;

        while (cyc < 98) begin
            next_cycle();
            applyStimulus(1'b1, 1'b0, cyc <= 97, 12'(32'h100 + cyc / 12));
            checkOutput("en_recurse", en_recurse, (cyc % 2) == 0);
            checkOutput("en_ds", en_ds, (cyc % 12) == 0);
            checkOutput("load_back", load_back, (cyc % 12) == 2);
            checkOutput("phase1", phase1, cyc % 2);
            checkOutput("phase2", phase2, (cyc / 2) % 6);
            checkOutput("valid_compute", valid_compute, cyc >= 72);
            checkOutput("out_valid_first", out_if.out_valid, cyc == 97);
            if (cyc == 97) checkOutput("out_data_first", out_if.out_data, 32'h108);
        end

        // Consumer stalls: four results held, later ones dropped, then drained.
        while (cyc < 190) begin
            next_cycle();
            applyStimulus(1'b1, cyc == 190, (cyc >= 184) && (cyc <= 187), 12'(32'h100 + cyc / 12));
            case (cyc)
                156: begin
                    checkOutput("ovf_before_drop", overflow, 0);
                    checkOutput("full_head", out_if.out_data, 32'h109);
                end
                157: begin
                    checkOutput("ovf_after_drop", overflow, 1);
                    checkOutput("head_stable", out_if.out_data, 32'h109);
                    checkOutput("valid_stable", out_if.out_valid, 1);
`ifdef HYBRID_SEQ_DROPCNT_EN
                    checkOutput("drop_cnt_1", drop_cnt, 1);
`endif
                end
`ifdef HYBRID_SEQ_DROPCNT_EN
                168: checkOutput("drop_cnt_still_1", drop_cnt, 1);
                181: checkOutput("drop_cnt_3", drop_cnt, 3);
`endif
                184: checkOutput("pop0", out_if.out_data, 32'h109);
                185: checkOutput("pop1", out_if.out_data, 32'h10A);
                186: checkOutput("pop2", out_if.out_data, 32'h10B);
                187: checkOutput("pop3", out_if.out_data, 32'h10C);
                188: checkOutput("drained", out_if.out_valid, 0);
                default: ;
            endcase
        end

        // Restart taken on this edge; schedule restarts from cycle 0.
        next_cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h200);
        cyc = 0;
        checkOutput("rs_valid_compute", valid_compute, 0);
        checkOutput("rs_out_valid", out_if.out_valid, 0);
        checkOutput("rs_overflow", overflow, 0);
        checkOutput("rs_phase1", phase1, 0);
        checkOutput("rs_phase2", phase2, 0);
        checkOutput("rs_en_ds", en_ds, 0);
`ifdef HYBRID_SEQ_DROPCNT_EN
        checkOutput("rs_drop_cnt", drop_cnt, 0);
`endif

        while (cyc < 156) begin
            next_cycle();
            applyStimulus(1'b1, 1'b0, (cyc == 144) || (cyc >= 146), 12'(32'h200 + cyc / 12));
            if (cyc <= 24) checkOutput("rs_en_ds_sched", en_ds, (cyc % 12) == 0);
            case (cyc)
                71:  checkOutput("rs_vc_low", valid_compute, 0);
                72:  checkOutput("rs_vc_high", valid_compute, 1);
                133: checkOutput("full_head2", out_if.out_data, 32'h208);
                145: begin
                    checkOutput("pushpop_valid", out_if.out_valid, 1);
                    checkOutput("pushpop_ovf", overflow, 0);
                    checkOutput("pushpop_head", out_if.out_data, 32'h209);
                end
                146: checkOutput("pp_pop0", out_if.out_data, 32'h209);
                147: checkOutput("pp_pop1", out_if.out_data, 32'h20A);
                148: checkOutput("pp_pop2", out_if.out_data, 32'h20B);
                149: checkOutput("pp_pop3", out_if.out_data, 32'h20C);
                150: begin
                    checkOutput("pp_drained", out_if.out_valid, 0);
                    checkOutput("pp_ovf", overflow, 0);
`ifdef HYBRID_SEQ_DROPCNT_EN
                    checkOutput("pp_drop_cnt", drop_cnt, 0);
`endif
                end
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a downsample strobe.
        checkOutput("pre_rst_en_ds", en_ds, 1);
        checkOutput("pre_rst_vc", valid_compute, 1);
        rst = 1'b0;
        #1;
        checkOutput("async_en_ds", en_ds, 0);
        checkOutput("async_en_recurse", en_recurse, 0);
        checkOutput("async_vc", valid_compute, 0);
        checkOutput("async_phase2", phase2, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        next_cycle();
        cyc = 0;
        while (cyc < 20) begin
            next_cycle();
            applyStimulus(cyc != 20, 1'b0, 1'b0, 12'h0);
            checkOutput("rr_en_ds", en_ds, cyc == 12);
            checkOutput("rr_en_recurse", en_recurse, (cyc % 2) == 0);
        end

        // start dropped mid-FILL: back to IDLE with counters cleared.
        next_cycle();
        checkOutput("stop_en_recurse", en_recurse, 0);
        checkOutput("stop_en_ds", en_ds, 0);
        checkOutput("stop_load_back", load_back, 0);
        checkOutput("stop_phase1", phase1, 0);
        checkOutput("stop_phase2", phase2, 0);
        checkOutput("stop_vc", valid_compute, 0);
        repeat (3) begin
            next_cycle();
            checkOutput("idle_strobe", en_recurse, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h0);
        next_cycle();
        cyc = 0;
        while (cyc < 12) begin
            next_cycle();
            checkOutput("restart_en_ds", en_ds, cyc == 12);
        end

        // DSR1 = DSR2 = 1 instance: every active cycle is a strobe.
        start_b = 1'b1;
        next_cycle();
        cyc = 0;
        checkOutput("b_idle_edge", en_recurse_b, 0);
        while (cyc < 7) begin
            next_cycle();
            checkOutput("b_en_recurse", en_recurse_b, 1);
            checkOutput("b_en_ds", en_ds_b, 1);
            checkOutput("b_load_back", load_back_b, 1);
            checkOutput("b_phases", {phase1_b, phase2_b}, 0);
            checkOutput("b_valid_compute", valid_compute_b, cyc >= 6);
        end
        checkOutput("b_out_valid", out_if_b.out_valid, 0);
        checkOutput("b_out_data", out_if_b.out_data, 0);
        checkOutput("b_overflow", overflow_b, 0);
`ifdef HYBRID_SEQ_DROPCNT_EN
        checkOutput("b_drop_cnt", drop_cnt_b, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
